kbd_wb_target: RTL and testbench
================================

// Module: kbd_wb_target
// PURPOSE
// - Wishbone responder holding the PET keyboard matrix: 10 columns x 8 rows, one byte per column.
// - The host initiator (SPI->WB bridge) writes key state into the column registers at WB_KBD_BASE.
// - Snoops CPU writes to PIA1 PORTA (KEY A-D) to latch the scanned column.
// - Returns that column's row byte to the PIA1 PORTB read path; the emulated PET sees its keyboard here.
// PARAMETERS
// - DATA_WIDTH      8   byte width of WB data, CPU data and row bus
// - KBD_COL_COUNT   10  number of implemented column registers
// - KBD_ADDR_WIDTH  4   column index width; also WB register-select width
// - WB_ADDR_WIDTH   20  Wishbone address width
// PORTS
// - clock_i           in   1   system clock, 64 MHz
// - reset_ni          in   1   synchronous reset, active low
// - wb_addr_i         in   20  WB address; only [KBD_ADDR_WIDTH-1:0] decoded
// - wb_data_i         in   8   WB write data
// - wb_data_o         out  8   WB read data, valid while wb_ack_o=1
// - wb_we_i           in   1   1=write, 0=read
// - wb_cyc_i          in   1   WB cycle
// - wb_stb_i          in   1   WB strobe; valid only when wb_sel_i=1 (address decoder hit on WB_KBD_BASE)
// - wb_sel_i          in   1   address decoder hit on WB_KBD_BASE
// - wb_ack_o          out  1   WB acknowledge
// - wb_stall_o        out  1   WB stall; tied 0
// - pia1_porta_we_i   in   1   1-cycle pulse: CPU write to PIA1 PORTA with CRA[2]=1 (PIBA) completed
// - cpu_data_i        in   8   CPU data bus, valid with pia1_porta_we_i
// - kbd_col_o         out  4   currently selected column (KEY A-D)
// - kbd_row_o         out  8   row byte of selected column, active-low (0 = key down)
// BEHAVIOUR
// - Reset (reset_ni=0 at posedge)
//   - all column registers = 8'hFF (no keys down); kbd_col_o = 0; kbd_row_o = 8'hFF
//   - wb_ack_o = 0; wb_data_o = 0
//   - reset overrides any write presented in the same cycle; that write is lost and not acked
// - Accept condition: wb_cyc_i & wb_stb_i & wb_sel_i at posedge. wb_stall_o is always 0, so a request is accepted every cycle it is presented.
// - Ack
//   - wb_ack_o = 1 exactly one cycle after each accept, otherwise 0
//   - back-to-back accepts give back-to-back acks, one per request, in order
//   - wb_cyc_i dropping before ack: the ack is still issued the next cycle, and the write has already taken effect
// - Write (accept & we)
//   - idx = wb_addr_i[3:0]; if idx < KBD_COL_COUNT, col[idx] <= wb_data_i at the accept edge
//   - idx 10..15: no state change, still acked
// - Read (accept & !we)
//   - wb_data_o <= col[idx] for idx < 10, else 8'hFF; registered with the ack
//   - wb_data_o holds its value when no read is in progress
// - Column select
//   - on pia1_porta_we_i: kbd_col_o <= cpu_data_i[3:0]
//   - upper nibble ignored (it is owned by other PET functions)
// - Row output
//   - kbd_row_o is registered: kbd_row_o <= (sel < 10) ? col[sel] : 8'hFF
//   - sel is the kbd_col_o value after the current edge's update; this gives 1-cycle latency from either a column-select pulse or a host write to the selected column
//   - out-of-range column 10..15 reads 8'hFF, matching real PET behaviour (no column driven)
// - Simultaneous events
//   - host write and pia1_porta_we_i in the same cycle both take effect
//   - kbd_row_o reflects the new column and the new data one cycle later
//   - host read and write to the same index cannot coincide (single port)
// - No internal FSM beyond the ack pipeline register. The block never initiates WB traffic.
// TESTING
// - Reset: reset_ni=0 for 2 cycles -> kbd_row_o=FF, kbd_col_o=0, wb_ack_o=0; WB read idx 0..9 -> all FF.
// - Write then read back: write idx3=8'hFE, then read idx3 -> ack exactly 1 cycle after each accept; read data FE; other columns still FF.
// - Column select: host writes idx5=8'h7F; pulse pia1_porta_we_i with cpu_data_i=8'hA5 -> kbd_col_o=5; kbd_row_o=7F on the next cycle.
// - Out of range: write idx12=8'h00 -> acked, no state change; read idx12 -> FF; CPU selects col 0x0B -> kbd_row_o=FF.
// - Simultaneous: host writes idx2=8'hBF in the same cycle as a CPU select of col 2 -> next cycle kbd_row_o=BF.
// - Pipelined bursts and reset: 4 back-to-back strobes (W0=11, W1=22, R0, R1) -> 4 consecutive acks; reads return 11 then 22.
// - Reset mid-burst: assert reset_ni=0 during the 3rd strobe -> no further acks; all columns FF after reset.

Source files
------------

// File: rtl/kbd_wb_target.sv
// PET keyboard matrix behind a Wishbone responder: the host writes column bytes,
// and the CPU's PIA1 PORTA writes pick the column whose row byte drives kbd_row_o.
module kbd_wb_target #(
    parameter int DATA_WIDTH     = 8,
    parameter int KBD_COL_COUNT  = 10,
    parameter int KBD_ADDR_WIDTH = 4,
    parameter int WB_ADDR_WIDTH  = 20
) (
    input  logic                      clock_i,
    input  logic                      reset_ni,
    input  logic [WB_ADDR_WIDTH-1:0]  wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    output logic [DATA_WIDTH-1:0]     wb_data_o,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_sel_i,
    output logic                      wb_ack_o,
    output logic                      wb_stall_o,
    input  logic                      pia1_porta_we_i,
    input  logic [DATA_WIDTH-1:0]     cpu_data_i,
    output logic [KBD_ADDR_WIDTH-1:0] kbd_col_o,
    output logic [DATA_WIDTH-1:0]     kbd_row_o
);

    localparam logic [KBD_ADDR_WIDTH-1:0] COL_LIMIT = KBD_ADDR_WIDTH'(KBD_COL_COUNT);

    logic [DATA_WIDTH-1:0]     col_reg  [KBD_COL_COUNT];
    logic [DATA_WIDTH-1:0]     col_next [KBD_COL_COUNT];
    logic                      accept;
    logic [KBD_ADDR_WIDTH-1:0] idx;
    logic [KBD_ADDR_WIDTH-1:0] sel_next;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic [DATA_WIDTH-1:0]     row_next;
    logic                      unused_bits;

    assign accept      = wb_cyc_i & wb_stb_i & wb_sel_i;
    assign idx         = wb_addr_i[KBD_ADDR_WIDTH-1:0];
    assign wb_stall_o  = 1'b0;
    assign unused_bits = ^{wb_addr_i[WB_ADDR_WIDTH-1:KBD_ADDR_WIDTH],
                           cpu_data_i[DATA_WIDTH-1:KBD_ADDR_WIDTH]};

    // Row byte is built from post-edge column select and post-edge matrix contents,
    // so a select pulse or a host write shows up on kbd_row_o one cycle later.
    always_comb begin
        col_next = col_reg;
        if (accept && wb_we_i && (idx < COL_LIMIT)) begin
            col_next[idx] = wb_data_i;
        end
        sel_next = pia1_porta_we_i ? cpu_data_i[KBD_ADDR_WIDTH-1:0] : kbd_col_o;
        row_next = '1;
        if (sel_next < COL_LIMIT) begin
            row_next = col_next[sel_next];
        end
        rd_data = '1;
        if (idx < COL_LIMIT) begin
            rd_data = col_reg[idx];
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            for (int i = 0; i < KBD_COL_COUNT; i++) begin
                col_reg[i] <= '1;
            end
            wb_ack_o  <= 1'b0;
            wb_data_o <= '0;
            kbd_col_o <= '0;
            kbd_row_o <= '1;
        end else begin
            for (int i = 0; i < KBD_COL_COUNT; i++) begin
                col_reg[i] <= col_next[i];
            end
            wb_ack_o <= accept;
            if (accept && !wb_we_i) begin
                wb_data_o <= rd_data;
            end
            kbd_col_o <= sel_next;
            kbd_row_o <= row_next;
        end
    end

endmodule

// File: tb/tb_kbd_wb_target.sv
// Bench for kbd_wb_target: WB responses go through a scoreboard queue checked by a
// monitor on ack; keyboard column/row outputs are checked directly after each step.
module tb_kbd_wb_target;

    typedef struct packed {
        bit         is_read;
        logic [7:0] data;
    } exp_t;

    logic        clock_i = 1'b0;
    logic        reset_ni;
    logic [19:0] wb_addr_i;
    logic [7:0]  wb_data_i;
    logic [7:0]  wb_data_o;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_sel_i;
    logic        wb_ack_o;
    logic        wb_stall_o;
    logic        pia1_porta_we_i;
    logic [7:0]  cpu_data_i;
    logic [3:0]  kbd_col_o;
    logic [7:0]  kbd_row_o;

    exp_t sb_q[$];
    bit   exp_ack;
    bit   mon_en;
    int   pass_count;
    int   check_count;

    kbd_wb_target dut (
        .clock_i         (clock_i),
        .reset_ni        (reset_ni),
        .wb_addr_i       (wb_addr_i),
        .wb_data_i       (wb_data_i),
        .wb_data_o       (wb_data_o),
        .wb_we_i         (wb_we_i),
        .wb_cyc_i        (wb_cyc_i),
        .wb_stb_i        (wb_stb_i),
        .wb_sel_i        (wb_sel_i),
        .wb_ack_o        (wb_ack_o),
        .wb_stall_o      (wb_stall_o),
        .pia1_porta_we_i (pia1_porta_we_i),
        .cpu_data_i      (cpu_data_i),
        .kbd_col_o       (kbd_col_o),
        .kbd_row_o       (kbd_row_o)
    );

    always #5 clock_i = ~clock_i;

    // Independent ack model: one cycle after any accepted request while out of reset.
    always @(posedge clock_i) begin
        exp_ack <= reset_ni && wb_cyc_i && wb_stb_i && wb_sel_i;
    end

    always @(negedge clock_i) begin
        if (mon_en) begin
            check_count++;
            if (wb_ack_o !== exp_ack) begin
                $display("[TB] FAIL ack_timing t=%0t actual=%b required=%b", $time, wb_ack_o, exp_ack);
            end else begin
                pass_count++;
            end
            if (wb_ack_o === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_count++;
                    $display("[TB] FAIL ack_unexpected t=%0t actual=ack required=no_ack", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.is_read) begin
                        check_count++;
                        if (wb_data_o !== e.data) begin
                            $display("[TB] FAIL read_data t=%0t actual=%h required=%h", $time, wb_data_o, e.data);
                        end else begin
                            pass_count++;
                        end
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] required);
        check_count++;
        if (actual !== required) begin
            $display("[TB] FAIL %s t=%0t actual=%h required=%h", name, $time, actual, required);
        end else begin
            pass_count++;
        end
    endtask

    // Presents one WB strobe for a single clock; expected response queued only if it can be accepted.
    task automatic apply_stimulus(input bit we, input logic [3:0] idx, input logic [7:0] data,
                                  input logic [7:0] exp_rd);
        exp_t e;
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_sel_i  = 1'b1;
        wb_we_i   = we;
        wb_addr_i = {16'h0000, idx};
        wb_data_i = data;
        if (reset_ni) begin
            e.is_read = !we;
            e.data    = exp_rd;
            sb_q.push_back(e);
        end
        @(posedge clock_i);
        #1;
    endtask

    task automatic wb_idle(input int cycles);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_sel_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (cycles) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    task automatic cpu_select(input logic [7:0] value);
        pia1_porta_we_i = 1'b1;
        cpu_data_i      = value;
        @(posedge clock_i);
        #1;
        pia1_porta_we_i = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        reset_ni = 1'b0;
        repeat (cycles) begin
            @(posedge clock_i);
            #1;
        end
        reset_ni = 1'b1;
    endtask

    initial begin
        pass_count      = 0;
        check_count     = 0;
        mon_en          = 1'b0;
        wb_addr_i       = '0;
        wb_data_i       = '0;
        wb_we_i         = 1'b0;
        wb_cyc_i        = 1'b0;
        wb_stb_i        = 1'b0;
        wb_sel_i        = 1'b0;
        pia1_porta_we_i = 1'b0;
        cpu_data_i      = '0;
        @(posedge clock_i);
        #1;
        apply_reset(2);
        mon_en = 1'b1;

        check_output("reset_row", kbd_row_o, 8'hFF);
        check_output("reset_col", {4'h0, kbd_col_o}, 8'h00);
        check_output("reset_ack", {7'h0, wb_ack_o}, 8'h00);
        check_output("reset_data", wb_data_o, 8'h00);
        check_output("stall_low", {7'h0, wb_stall_o}, 8'h00);

        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 4'(i), 8'h00, 8'hFF);
        wb_idle(2);

        apply_stimulus(1'b1, 4'd3, 8'hFE, 8'h00);
        wb_idle(1);
        apply_stimulus(1'b0, 4'd3, 8'h00, 8'hFE);
        apply_stimulus(1'b0, 4'd4, 8'h00, 8'hFF);
        apply_stimulus(1'b0, 4'd2, 8'h00, 8'hFF);
        wb_idle(2);

        apply_stimulus(1'b1, 4'd5, 8'h7F, 8'h00);
        wb_idle(1);
        cpu_select(8'hA5);
        check_output("select_col5", {4'h0, kbd_col_o}, 8'h05);
        check_output("select_row5", kbd_row_o, 8'h7F);

        apply_stimulus(1'b1, 4'd12, 8'h00, 8'h00);
        apply_stimulus(1'b0, 4'd12, 8'h00, 8'hFF);
        apply_stimulus(1'b0, 4'd4, 8'h00, 8'hFF);
        apply_stimulus(1'b0, 4'd15, 8'h00, 8'hFF);
        wb_idle(1);
        cpu_select(8'h0B);
        check_output("oor_col", {4'h0, kbd_col_o}, 8'h0B);
        check_output("oor_row", kbd_row_o, 8'hFF);

        pia1_porta_we_i = 1'b1;
        cpu_data_i      = 8'hF2;
        apply_stimulus(1'b1, 4'd2, 8'hBF, 8'h00);
        pia1_porta_we_i = 1'b0;
        wb_idle(0);
        check_output("simul_col", {4'h0, kbd_col_o}, 8'h02);
        check_output("simul_row", kbd_row_o, 8'hBF);

        apply_stimulus(1'b1, 4'd2, 8'h3C, 8'h00);
        wb_idle(0);
        check_output("host_update_row", kbd_row_o, 8'h3C);
        apply_stimulus(1'b1, 4'd7, 8'h81, 8'h00);
        wb_idle(0);
        check_output("other_col_row", kbd_row_o, 8'h3C);
        wb_idle(1);

        apply_stimulus(1'b1, 4'd0, 8'h11, 8'h00);
        apply_stimulus(1'b1, 4'd1, 8'h22, 8'h00);
        apply_stimulus(1'b0, 4'd0, 8'h00, 8'h11);
        apply_stimulus(1'b0, 4'd1, 8'h00, 8'h22);
        wb_idle(2);

        apply_stimulus(1'b1, 4'd0, 8'h55, 8'h00);
        apply_stimulus(1'b1, 4'd1, 8'h66, 8'h00);
        reset_ni = 1'b0;
        apply_stimulus(1'b1, 4'd2, 8'h77, 8'h00);
        apply_stimulus(1'b1, 4'd3, 8'h78, 8'h00);
        reset_ni = 1'b1;
        wb_idle(2);
        check_output("post_reset_row", kbd_row_o, 8'hFF);
        check_output("post_reset_col", {4'h0, kbd_col_o}, 8'h00);
        check_output("post_reset_data", wb_data_o, 8'h00);
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 4'(i), 8'h00, 8'hFF);
        wb_idle(3);

        check_output("sb_drained", 8'(sb_q.size()), 8'h00);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
